// File: rtl/regfile_write_sequencer_if.sv
// Write-port bus between the WB stage / debug loader (master) and the
// register-file write sequencer (slave).
interface regfile_write_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
);
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              timer_intrpt;
    logic              ext_intrpt;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_ack;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_we_n;
    logic              busy;
    logic [CNT_W-1:0]  wb_drop_cnt;

    modport master (
        output wb_valid, wb_addr, wb_data, timer_intrpt, ext_intrpt,
               dbg_req, dbg_addr, dbg_data,
        input  dbg_ack, rf_write_addr, rf_write_data, rf_we_n, busy, wb_drop_cnt
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, timer_intrpt, ext_intrpt,
               dbg_req, dbg_addr, dbg_data,
        output dbg_ack, rf_write_addr, rf_write_data, rf_we_n, busy, wb_drop_cnt
    );
endinterface

// File: rtl/regfile_write_sequencer.sv
// Single write port arbiter for the integer register file: post-reset clear,
// WB writeback with interrupt suppression, and debug loader. Clear is built only with RF_CLEAR_EN.
module regfile_write_sequencer #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    regfile_write_sequencer_if.slave    bus
);
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    if (NUM_REGS < 2 || NUM_REGS > (1 << ADDR_W)) begin : g_bad_num_regs
        $error("NUM_REGS out of range for ADDR_W");
    end

    logic              intr_q;
    logic              wb_sup;
    logic              wb_go;
    logic              dbg_go;
    logic [0:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              we_n_q;
    logic              ack_q;
    logic [CNT_W-1:0]  drop_q;

    // Suppression window is the interrupt cycle plus the one after it.
    always_comb begin
        wb_sup = bus.wb_valid & (bus.timer_intrpt | bus.ext_intrpt | intr_q);
        wb_go  = bus.wb_valid & ~wb_sup;
        dbg_go = ~wb_go & bus.dbg_req & ~ack_q;
    end

`ifdef RF_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
    logic [ADDR_W-1:0] clr_ptr;
    logic              busy_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_CLEAR;
            clr_ptr <= ADDR_W'(1);
            busy_q  <= 1'b1;
        end else if (state == ST_CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
            if (clr_ptr == LAST_REG) state <= ST_RUN;
            busy_q  <= 1'b1;
        end else begin
            busy_q  <= 1'b0;
        end
    end

    assign bus.busy = busy_q;
`else
    assign state    = ST_RUN;
    assign bus.busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            we_n_q <= 1'b1;
            addr_q <= '0;
            data_q <= '0;
            ack_q  <= 1'b0;
            drop_q <= '0;
            intr_q <= 1'b0;
        end else begin
            intr_q <= bus.timer_intrpt | bus.ext_intrpt;
            we_n_q <= 1'b1;
            ack_q  <= 1'b0;
            if (state == ST_CLEAR) begin
`ifdef RF_CLEAR_EN
                we_n_q <= 1'b0;
                addr_q <= clr_ptr;
                data_q <= '0;
`endif
            end else begin
                // x0 is hardwired: never written and never counted as a drop.
                if (wb_sup && bus.wb_addr != '0 && drop_q != {CNT_W{1'b1}})
                    drop_q <= drop_q + 1'b1;
                if (wb_go) begin
                    if (bus.wb_addr != '0) begin
                        we_n_q <= 1'b0;
                        addr_q <= bus.wb_addr;
                        data_q <= bus.wb_data;
                    end
                end else if (dbg_go) begin
                    ack_q <= 1'b1;
                    if (bus.dbg_addr != '0) begin
                        we_n_q <= 1'b0;
                        addr_q <= bus.dbg_addr;
                        data_q <= bus.dbg_data;
                    end
                end
            end
        end
    end

    assign bus.rf_we_n       = we_n_q;
    assign bus.rf_write_addr = addr_q;
    assign bus.rf_write_data = data_q;
    assign bus.dbg_ack       = ack_q;
    assign bus.wb_drop_cnt   = drop_q;
endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed self-checking bench for regfile_write_sequencer; clear-sequence
// checks are compiled in when RF_CLEAR_EN is defined.
module tb_regfile_write_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    regfile_write_sequencer_if #(.ADDR_W(5), .DATA_W(32), .CNT_W(8)) bus ();

    regfile_write_sequencer #(.ADDR_W(5), .DATA_W(32), .NUM_REGS(32), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [31:0] a, input logic [31:0] d);
        chk({tag, "_we_n"}, 32'(bus.rf_we_n), 32'd0);
        chk({tag, "_addr"}, 32'(bus.rf_write_addr), a);
        chk({tag, "_data"}, bus.rf_write_data, d);
    endtask

    task automatic idle();
        bus.wb_valid     = 1'b0;
        bus.wb_addr      = '0;
        bus.wb_data      = '0;
        bus.timer_intrpt = 1'b0;
        bus.ext_intrpt   = 1'b0;
        bus.dbg_req      = 1'b0;
        bus.dbg_addr     = '0;
        bus.dbg_data     = '0;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        tick();
        tick();
        chk("rst_we_n", 32'(bus.rf_we_n), 32'd1);
        chk("rst_addr", 32'(bus.rf_write_addr), 32'd0);
        chk("rst_data", bus.rf_write_data, 32'd0);
        chk("rst_ack", 32'(bus.dbg_ack), 32'd0);
        chk("rst_drop", 32'(bus.wb_drop_cnt), 32'd0);
`ifdef RF_CLEAR_EN
        chk("rst_busy", 32'(bus.busy), 32'd1);
        // WB traffic during clear must be ignored and not counted.
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hFFFF_FFFF;
        bus.timer_intrpt = 1'b1;
        reset = 1'b1;
        for (int i = 1; i < 32; i++) begin
            tick();
            chk_wr($sformatf("clr%0d", i), 32'(i), 32'd0);
            chk("clr_busy", 32'(bus.busy), 32'd1);
        end
        idle();
        tick();
        chk("clr_done_busy", 32'(bus.busy), 32'd0);
        chk("clr_done_we_n", 32'(bus.rf_we_n), 32'd1);
        chk("clr_no_drop", 32'(bus.wb_drop_cnt), 32'd0);
        // Reset with the pointer at 12 restarts the sweep at x1.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 1; i < 12; i++) tick();
        chk("mid_clr_addr11", 32'(bus.rf_write_addr), 32'd11);
        reset = 1'b0;
        tick();
        chk("mid_rst_we_n", 32'(bus.rf_we_n), 32'd1);
        chk("mid_rst_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick();
        chk_wr("restart", 32'd1, 32'd0);
        for (int i = 2; i < 32; i++) tick();
        chk_wr("restart_last", 32'd31, 32'd0);
        tick();
        chk("restart_busy", 32'(bus.busy), 32'd0);
`else
        chk("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;
        tick();
        chk("run_busy", 32'(bus.busy), 32'd0);
        chk("run_idle_we_n", 32'(bus.rf_we_n), 32'd1);
`endif

        // WB latency
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEAD_BEEF;
        tick();
        chk_wr("wb", 32'd5, 32'hDEAD_BEEF);
        idle();
        tick();
        chk("wb_next_we_n", 32'(bus.rf_we_n), 32'd1);
        chk("wb_hold_addr", 32'(bus.rf_write_addr), 32'd5);
        chk("wb_hold_data", bus.rf_write_data, 32'hDEAD_BEEF);

        // Interrupt suppression: interrupt cycle plus one
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd6; bus.wb_data = 32'h0000_0A01;
        bus.timer_intrpt = 1'b1;
        tick();
        chk("sup0_we_n", 32'(bus.rf_we_n), 32'd1);
        chk("sup0_drop", 32'(bus.wb_drop_cnt), 32'd1);
        bus.timer_intrpt = 1'b0; bus.wb_data = 32'h0000_0A02;
        tick();
        chk("sup1_we_n", 32'(bus.rf_we_n), 32'd1);
        chk("sup1_drop", 32'(bus.wb_drop_cnt), 32'd2);
        bus.wb_data = 32'h0000_0A03;
        tick();
        chk_wr("sup2", 32'd6, 32'h0000_0A03);
        chk("sup2_drop", 32'(bus.wb_drop_cnt), 32'd2);

        // Suppressed WB frees the slot for debug (external interrupt)
        bus.ext_intrpt = 1'b1; bus.wb_addr = 5'd8;
        bus.dbg_req = 1'b1; bus.dbg_addr = 5'd9; bus.dbg_data = 32'h0000_5A5A;
        tick();
        chk_wr("sup_dbg", 32'd9, 32'h0000_5A5A);
        chk("sup_dbg_ack", 32'(bus.dbg_ack), 32'd1);
        chk("sup_dbg_drop", 32'(bus.wb_drop_cnt), 32'd3);
        idle();
        tick();
        chk("sup_dbg_ack_end", 32'(bus.dbg_ack), 32'd0);

        // Contention: WB wins for 3 cycles, then debug
        bus.dbg_req = 1'b1; bus.dbg_addr = 5'd7; bus.dbg_data = 32'h0000_1234;
        for (int i = 1; i <= 3; i++) begin
            bus.wb_valid = 1'b1; bus.wb_addr = 5'(i + 10); bus.wb_data = 32'(i * 16'h111);
            tick();
            chk_wr($sformatf("cont_wb%0d", i), 32'(i + 10), 32'(i * 16'h111));
            chk("cont_ack_low", 32'(bus.dbg_ack), 32'd0);
        end
        bus.wb_valid = 1'b0;
        tick();
        chk_wr("cont_dbg", 32'd7, 32'h0000_1234);
        chk("cont_ack", 32'(bus.dbg_ack), 32'd1);
        idle();
        tick();
        chk("cont_ack_once", 32'(bus.dbg_ack), 32'd0);
        chk("cont_no_dup", 32'(bus.rf_we_n), 32'd1);

        // Held request across the ack cycle is not sampled twice
        bus.dbg_req = 1'b1; bus.dbg_addr = 5'd4; bus.dbg_data = 32'h0000_00C4;
        tick();
        chk("hold_ack", 32'(bus.dbg_ack), 32'd1);
        tick();
        chk("hold_ack_gap", 32'(bus.dbg_ack), 32'd0);
        chk("hold_no_write", 32'(bus.rf_we_n), 32'd1);
        idle();
        tick();

        // Address 0
        bus.dbg_req = 1'b1; bus.dbg_addr = 5'd0; bus.dbg_data = 32'hFFFF_0000;
        tick();
        chk("a0_dbg_ack", 32'(bus.dbg_ack), 32'd1);
        chk("a0_dbg_we_n", 32'(bus.rf_we_n), 32'd1);
        idle();
        tick();
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h1111_1111;
        tick();
        chk("a0_wb_we_n", 32'(bus.rf_we_n), 32'd1);
        chk("a0_wb_drop", 32'(bus.wb_drop_cnt), 32'd3);
        idle();
        tick();

        // Drop counter saturation
        bus.timer_intrpt = 1'b1; bus.wb_valid = 1'b1; bus.wb_addr = 5'd9;
        for (int i = 0; i < 300; i++) tick();
        chk("sat_drop", 32'(bus.wb_drop_cnt), 32'd255);
        chk("sat_we_n", 32'(bus.rf_we_n), 32'd1);
        idle();
        tick();
        tick();
        chk("sat_hold", 32'(bus.wb_drop_cnt), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_write_sequencer.md
Name: regfile_write_sequencer

Overview:
- Owns the single write port of the 32x32 integer register file.
- Three write sources:
  - post-reset clear sequencer;
  - pipeline writeback (WB), highest priority in normal operation;
  - debug/UART loader over a req/ack handshake.
- Applies interrupt write suppression to WB only.
- Sits between the WB stage, the UART debug block and the register file.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NUM_REGS, 32, register count; clear covers 1..NUM_REGS-1.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset.
- wb_valid  input  1  WB stage requests a register write this cycle.
- wb_addr  input  ADDR_W  WB destination register.
- wb_data  input  DATA_W  WB write data.
- timer_intrpt  input  1  timer interrupt taken this cycle.
- ext_intrpt  input  1  external interrupt taken this cycle.
- dbg_req  input  1  debug write request; level, held until dbg_ack.
- dbg_addr  input  ADDR_W  debug destination register; stable while dbg_req=1.
- dbg_data  input  DATA_W  debug write data; stable while dbg_req=1.
- dbg_ack  output  1  one-cycle pulse: debug write performed.
- rf_write_addr  output  ADDR_W  to register file writeAddr.
- rf_write_data  output  DATA_W  to register file writeData.
- rf_we_n  output  1  to register file write enable; active-low, 0 = write.
- busy  output  1  clear in progress; pipeline must stall.
- wb_drop_cnt  output  CNT_W  saturating count of suppressed WB writes.

Behaviour:
- All outputs are registered. A source sampled at posedge N drives the rf_* outputs for exactly cycle N+1. The register file captures them on the intervening negedge.
- Reset (reset=0 at posedge) values:
  - rf_we_n=1, rf_write_addr=0, rf_write_data=0;
  - dbg_ack=0, busy=1 (busy=0 if RF_CLEAR_EN is undefined);
  - wb_drop_cnt=0, intr_q=0;
  - clear pointer=1, state=CLEAR (RUN if RF_CLEAR_EN is undefined).
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each cycle writes data 0 to the address held in the clear pointer, then increments the pointer.
  - After NUM_REGS-1 writes (x1..x31) the FSM moves to RUN.
  - busy=1 for every CLEAR cycle; busy=0 from the first RUN cycle.
  - wb_valid and dbg_req are ignored. WB writes arriving during CLEAR are not counted as drops.
  - Reset asserted mid-clear restarts the sequence at x1.
- RUN, per-cycle source priority:
  1. Suppressed WB: wb_valid=1 and (timer_intrpt | ext_intrpt | intr_q).
     - No write for WB; wb_drop_cnt increments, saturating at all-ones.
     - The slot is free for debug.
  2. WB: wb_valid=1, not suppressed.
     - Writes wb_addr/wb_data.
     - A pending debug request waits.
  3. Debug: dbg_req=1 and dbg_ack=0.
     - Writes dbg_addr/dbg_data; dbg_ack=1 next cycle.
     - dbg_req is not sampled in any cycle where dbg_ack=1.
     - The requester deasserts or changes the request in the ack cycle.
  4. None: rf_we_n=1; rf_write_addr and rf_write_data hold their last values.
- intr_q is registered each posedge as (timer_intrpt | ext_intrpt). Suppression therefore covers the interrupt cycle plus one following cycle.
- Address 0 from WB or debug:
  - rf_we_n stays 1 (no write);
  - the debug handshake still completes with dbg_ack=1;
  - a WB write to address 0 is not counted as a drop.
- Simultaneous WB and debug requests: WB wins. Debug is accepted in the first cycle with no unsuppressed WB.
- Debug starvation under continuous WB is permitted; there is no fairness guarantee.

Optional Feature:
- Macro RF_CLEAR_EN.
- Defined: after reset, the CLEAR sequence zeroes x1..x31 (31 cycles, busy=1) before RUN.
- Undefined:
  - reset enters RUN directly, with busy tied to 0;
  - no clear pointer logic is present;
  - register contents after reset are whatever the register file's initial image provides.

Test Plan:
- Clear: with RF_CLEAR_EN, release reset → rf_we_n=0 for 31 consecutive cycles, rf_write_addr 1..31, data 0; busy=1 for those cycles, then busy=0.
- WB latency: wb_valid=1, wb_addr=5, wb_data=0xDEADBEEF at posedge N → in cycle N+1, rf_we_n=0, addr=5, data=0xDEADBEEF; in cycle N+2, rf_we_n=1.
- Interrupt suppression: timer_intrpt=1 at N with wb_valid=1 for N..N+2 → writes suppressed at N and N+1; write occurs only for the WB sampled at N+2; wb_drop_cnt=2.
- Contention: dbg_req=1 (addr 7, data 0x1234) together with wb_valid=1 for 3 cycles, then WB idle → 3 WB writes, then the debug write to x7 with dbg_ack high for exactly one cycle, no duplicate write.
- Address 0: dbg_req=1, dbg_addr=0 → dbg_ack pulses, rf_we_n stays 1. wb_valid=1, wb_addr=0 → no write, wb_drop_cnt unchanged.
- Reset mid-clear and saturation:
  - reset=0 at clear pointer=12 → clear restarts at x1;
  - 300 suppressed WB writes with CNT_W=8 → wb_drop_cnt=255.
